// File: rtl/int2flt_pkg.sv
// Shared types and constants for the int16 -> binary16 converter.
// Default build truncates; define INT2FLT_RNE_EN for round-to-nearest-even.
package int2flt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        LD_LO,
        NORM,
        RND,
        ST_HI,
        ST_LO,
        DONE
    } state_t;

    localparam int BIAS   = 15;
    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;

    localparam int IN_ADDR_DEF   = 0;
    localparam int OUT_ADDR_DEF  = 2;
    localparam int MEM_DEPTH_DEF = 256;

    // Exponent of a value whose leading one sits in bit 15.
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + 15);

    // -32768 maps onto itself, which reads correctly as unsigned 0x8000.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/dat_mem.sv
// Single-port byte memory: synchronous write, combinational read.
// Shared with the sibling converters so one bench can backdoor-load it.
module dat_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_core [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_core[addr] <= wdata;
    end

    assign rdata = mem_core[addr];

endmodule

// File: rtl/int2flt.sv
// Converts a 16-bit signed integer in dm1 into an IEEE half in dm1.
// Rounding: truncation by default, RNE when INT2FLT_RNE_EN is defined.
module int2flt
    import int2flt_pkg::*;
#(
    parameter int IN_ADDR   = IN_ADDR_DEF,
    parameter int OUT_ADDR  = OUT_ADDR_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ack
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t state, nxt;

    logic [7:0]        hi_q;
    logic              sign_q;
    logic [15:0]       mag_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] mant_q;

    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;

    logic              mag_zero;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W-1:0] rnd_mant;
    logic              rnd_carry;

    dat_mem #(
        .DEPTH (MEM_DEPTH)
    ) dm1 (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign mag_zero = (mag_q == 16'd0);

    always_comb begin
        guard  = mag_q[4];
        sticky = |mag_q[3:0];
`ifdef INT2FLT_RNE_EN
        inc = guard & (sticky | mag_q[5]);
`else
        inc = 1'b0;
`endif
        {rnd_carry, rnd_mant} = {1'b0, mag_q[14:5]} + (MANT_W+1)'(inc);
    end

    always_comb begin
        nxt   = state;
        we    = 1'b0;
        addr  = AW'(IN_ADDR);
        wdata = 8'h00;
        unique case (state)
            IDLE:  if (req) nxt = LD_HI;
            LD_HI: nxt = LD_LO;
            LD_LO: begin
                addr = AW'(IN_ADDR + 1);
                nxt  = NORM;
            end
            NORM:  if (mag_zero || mag_q[15]) nxt = RND;
            RND:   nxt = ST_HI;
            ST_HI: begin
                addr  = AW'(OUT_ADDR);
                we    = 1'b1;
                wdata = {sign_q, exp_q, mant_q[9:8]};
                nxt   = ST_LO;
            end
            ST_LO: begin
                addr  = AW'(OUT_ADDR + 1);
                we    = 1'b1;
                wdata = mant_q[7:0];
                nxt   = DONE;
            end
            DONE:  if (req) nxt = LD_HI;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ack    <= 1'b0;
            hi_q   <= '0;
            sign_q <= 1'b0;
            mag_q  <= '0;
            exp_q  <= '0;
            mant_q <= '0;
        end else begin
            state <= nxt;
            ack   <= (nxt == DONE);
            unique case (state)
                LD_HI: hi_q <= rdata;
                LD_LO: begin
                    sign_q <= hi_q[7];
                    mag_q  <= abs16({hi_q, rdata});
                    exp_q  <= EXP_INIT;
                end
                NORM: begin
                    if (!mag_zero && !mag_q[15]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                end
                RND: begin
                    // Zero skips normalisation; force an all-zero encoding.
                    if (mag_zero) begin
                        exp_q  <= '0;
                        mant_q <= '0;
                    end else begin
                        mant_q <= rnd_mant;
                        exp_q  <= exp_q + EXP_W'(rnd_carry);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
